// File: rtl/fc_apu_dispatcher.sv
// fc_apu_dispatcher: core-side initiator for the APU request/response port.
// Holds one FP command stable on the APU port until it is granted. Keeps the
// destination tags of in-flight ops in an in-order FIFO, and pairs each
// response with the head tag for register-file writeback.
module fc_apu_dispatcher #(
   parameter int unsigned NARGS           = 3,
   parameter int unsigned WOP             = 6,
   parameter int unsigned NDSFLAGS        = 15,
   parameter int unsigned NUSFLAGS        = 5,
   parameter int unsigned TAG_W           = 5,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [NARGS*32-1:0]   cmd_operands_i,
   input  logic [WOP-1:0]        cmd_op_i,
   input  logic [NDSFLAGS-1:0]   cmd_flags_i,
   input  logic [TAG_W-1:0]      cmd_rd_i,
   output logic                  apu_req_o,
   input  logic                  apu_gnt_i,
   output logic [NARGS*32-1:0]   apu_operands_o,
   output logic [WOP-1:0]        apu_op_o,
   output logic [NDSFLAGS-1:0]   apu_flags_o,
   input  logic                  apu_rvalid_i,
   input  logic [31:0]           apu_rdata_i,
   input  logic [NUSFLAGS-1:0]   apu_rflags_i,
   output logic                  wb_valid_o,
   output logic [TAG_W-1:0]      wb_rd_o,
   output logic [31:0]           wb_data_o,
   output logic [NUSFLAGS-1:0]   wb_flags_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_OUTSTANDING);

   // Issue register
   logic                  r_req;
   logic [NARGS*32-1:0]   r_operands;
   logic [WOP-1:0]        r_op;
   logic [NDSFLAGS-1:0]   r_flags;

   // Tag FIFO
   logic [TAG_W-1:0]      r_tags [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [OCC_W-1:0]      r_occ;

   // Writeback and status
   logic                  r_wb_valid;
   logic [TAG_W-1:0]      r_wb_rd;
   logic [31:0]           r_wb_data;
   logic [NUSFLAGS-1:0]   r_wb_flags;
   logic                  r_busy;
   logic                  r_err;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_ready;
   logic                  w_hazard;
   logic [OCC_W-1:0]      w_occ_next;
   logic [MAX_OUTSTANDING-1:0] w_live;

   // A response pops only when something is in flight; otherwise it is spurious.
   assign w_pop   = apu_rvalid_i & (r_occ != '0);
   assign w_ready = (~r_req | apu_gnt_i) & ((r_occ < OCC_MAX) | apu_rvalid_i) & ~w_hazard;
   assign w_push  = cmd_valid_i & w_ready;

   // An entry is live when it lies within occ of the read pointer; the head is
   // released early when it is being popped this cycle.
   for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_live
      logic [PTR_W-1:0] w_off;
      assign w_off     = PTR_W'(g) - r_rptr;
      assign w_live[g] = ({1'b0, w_off} < r_occ) & ~(w_pop & (w_off == '0));
   end

   // Destination-register hazard against every live in-flight tag.
   always_comb begin
      // NOTE: default assigned first so every path drives the signal (no latch).
      w_hazard = 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (w_live[i] && (r_tags[i] == cmd_rd_i)) w_hazard = 1'b1;
      end
   end

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_occ_next = r_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_next = r_occ + OCC_W'(1);
         2'b01:   w_occ_next = r_occ - OCC_W'(1);
         default: w_occ_next = r_occ;
      endcase
   end

   // Issue register: latch payload on accept, drop request on grant.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_req      <= 1'b0;
         r_operands <= '0;
         r_op       <= '0;
         r_flags    <= '0;
      end else if (w_push) begin
         r_req      <= 1'b1;
         r_operands <= cmd_operands_i;
         r_op       <= cmd_op_i;
         r_flags    <= cmd_flags_i;
      end else if (apu_gnt_i) begin
         r_req      <= 1'b0;
      end
   end

   // Tag storage: written on push only.
   // NOTE: storage is not reset; liveness comes from pointers and occ alone.
   always_ff @(posedge clk_i) begin
      if (w_push) r_tags[r_wptr] <= cmd_rd_i;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_occ <= w_occ_next;
      end
   end

   // Writeback: pair the response with the head tag, one-cycle pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_wb_flags <= '0;
      end else begin
         r_wb_valid <= w_pop;
         if (w_pop) begin
            r_wb_rd    <= r_tags[r_rptr];
            r_wb_data  <= apu_rdata_i;
            r_wb_flags <= apu_rflags_i;
         end
      end
   end

   // Status: busy while anything is in flight or a writeback is pending; sticky error.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_busy <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= (w_occ_next != '0) | w_pop;
         if (apu_rvalid_i && (r_occ == '0)) r_err <= 1'b1;
      end
   end

   assign cmd_ready_o    = w_ready;
   assign apu_req_o      = r_req;
   assign apu_operands_o = r_operands;
   assign apu_op_o       = r_op;
   assign apu_flags_o    = r_flags;
   assign wb_valid_o     = r_wb_valid;
   assign wb_rd_o        = r_wb_rd;
   assign wb_data_o      = r_wb_data;
   assign wb_flags_o     = r_wb_flags;
   assign busy_o         = r_busy;
   assign err_o          = r_err;

endmodule

// File: tb/tb_fc_apu_dispatcher.sv
// tb_fc_apu_dispatcher: directed stimulus with a scoreboard. Expected grant
// payloads and writebacks are queued when stimulus is issued; a monitor on the
// falling edge pops and compares whenever the DUT grants or writes back.
module tb_fc_apu_dispatcher;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [95:0]   cmd_operands_i;
   logic [5:0]    cmd_op_i;
   logic [14:0]   cmd_flags_i;
   logic [4:0]    cmd_rd_i;
   logic          apu_req_o;
   logic          apu_gnt_i;
   logic [95:0]   apu_operands_o;
   logic [5:0]    apu_op_o;
   logic [14:0]   apu_flags_o;
   logic          apu_rvalid_i;
   logic [31:0]   apu_rdata_i;
   logic [4:0]    apu_rflags_i;
   logic          wb_valid_o;
   logic [4:0]    wb_rd_o;
   logic [31:0]   wb_data_o;
   logic [4:0]    wb_flags_o;
   logic          busy_o;
   logic          err_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_wb    = 0;

   logic [127:0] req_q[$];
   logic [127:0] wb_q[$];

   fc_apu_dispatcher dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_operands_i(cmd_operands_i), .cmd_op_i(cmd_op_i),
      .cmd_flags_i(cmd_flags_i), .cmd_rd_i(cmd_rd_i),
      .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
      .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
      .apu_flags_o(apu_flags_o),
      .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i),
      .apu_rflags_i(apu_rflags_i),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .wb_flags_o(wb_flags_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic neg();
      @(negedge clk_i);
   endtask

   function automatic logic [95:0] ops_of(input logic [4:0] rd);
      return {32'hC000_0000 | 32'(rd), 32'hB000_0000 | 32'(rd), 32'hA000_0000 | 32'(rd)};
   endfunction

   function automatic logic [14:0] flags_of(input logic [4:0] rd);
      return 15'h1200 | 15'(rd);
   endfunction

   function automatic logic [127:0] req_exp(input logic [4:0] rd, input logic [5:0] op);
      return {11'b0, ops_of(rd), op, flags_of(rd)};
   endfunction

   function automatic logic [127:0] wb_exp(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] f);
      return {86'b0, rd, d, f};
   endfunction

   task automatic drive_cmd(input logic [4:0] rd, input logic [5:0] op);
      cmd_valid_i    = 1'b1;
      cmd_rd_i       = rd;
      cmd_op_i       = op;
      cmd_operands_i = ops_of(rd);
      cmd_flags_i    = flags_of(rd);
   endtask

   task automatic drive_rsp(input logic [4:0] exp_rd, input logic [31:0] d, input logic [4:0] f);
      apu_rvalid_i = 1'b1;
      apu_rdata_i  = d;
      apu_rflags_i = f;
      wb_q.push_back(wb_exp(exp_rd, d, f));
   endtask

   // Monitor: compare each granted payload and each writeback against the queues.
   always @(negedge clk_i) begin
      if (apu_req_o === 1'b1 && apu_gnt_i === 1'b1) begin
         if (req_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_unexpected: got %0h, expected no request", apu_operands_o);
         end else begin
            check("grant_payload", {11'b0, apu_operands_o, apu_op_o, apu_flags_o}, req_q.pop_front());
         end
      end
      if (wb_valid_o === 1'b1) begin
         n_wb++;
         if (wb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wb_unexpected: got rd=%0d data=%0h, expected no writeback", wb_rd_o, wb_data_o);
         end else begin
            check("wb_payload", {86'b0, wb_rd_o, wb_data_o, wb_flags_o}, wb_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb0;
      rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_operands_i = '0; cmd_op_i = '0;
      cmd_flags_i = '0; cmd_rd_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
      apu_rdata_i = '0; apu_rflags_i = '0;
      tick(); tick();
      neg();
      check("reset_ctrl", {apu_req_o, wb_valid_o, busy_o, err_o}, 4'b0000);
      check("reset_payload", {apu_operands_o, apu_op_o, apu_flags_o}, '0);
      check("reset_wb", {wb_rd_o, wb_data_o, wb_flags_o}, '0);
      rst_ni = 1'b1;
      tick();

      // 1: single op, grant with request, response two cycles later
      wb0 = n_wb;
      drive_cmd(5'd3, 6'h00);
      neg(); check("t1_ready", cmd_ready_o, 1'b1);
      req_q.push_back(req_exp(5'd3, 6'h00));
      tick();
      cmd_valid_i = 1'b0; apu_gnt_i = 1'b1;
      neg(); check("t1_req", {apu_req_o, busy_o}, 2'b11);
      tick();
      apu_gnt_i = 1'b0;
      neg(); check("t1_req_drop", apu_req_o, 1'b0);
      tick();
      drive_rsp(5'd3, 32'h3F80_0000, 5'h01);
      tick();
      apu_rvalid_i = 1'b0;
      neg(); check("t1_busy_wb", {wb_valid_o, busy_o}, 2'b11);
      tick();
      neg(); check("t1_busy_fall", {wb_valid_o, busy_o}, 2'b00);
      check("t1_wb_count", n_wb - wb0, 1);
      tick();

      // 2: grant held low five cycles
      drive_cmd(5'd9, 6'h05);
      req_q.push_back(req_exp(5'd9, 6'h05));
      tick();
      drive_cmd(5'd10, 6'h07);
      for (int i = 0; i < 5; i++) begin
         neg();
         check("t2_hold", {apu_req_o, cmd_ready_o, apu_operands_o, apu_op_o, apu_flags_o},
               {1'b1, 1'b0, ops_of(5'd9), 6'h05, flags_of(5'd9)});
         tick();
      end
      cmd_valid_i = 1'b0; apu_gnt_i = 1'b1;
      tick();
      apu_gnt_i = 1'b0;
      drive_rsp(5'd9, 32'h4000_0000, 5'h00);
      tick();
      apu_rvalid_i = 1'b0;
      tick();
      neg(); check("t2_one_push", {busy_o, err_o}, 2'b00);
      tick();

      // 3: five back-to-back, FIFO fills at four
      apu_gnt_i = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         drive_cmd(5'(r), 6'h02);
         neg(); check("t3_ready", cmd_ready_o, 1'b1);
         req_q.push_back(req_exp(5'(r), 6'h02));
         tick();
      end
      drive_cmd(5'd5, 6'h02);
      neg(); check("t3_full_stall", cmd_ready_o, 1'b0);
      tick();
      drive_rsp(5'd1, 32'h1111_0001, 5'h02);
      neg(); check("t3_pop_accept", cmd_ready_o, 1'b1);
      req_q.push_back(req_exp(5'd5, 6'h02));
      tick();
      cmd_valid_i = 1'b0;
      for (int r = 2; r <= 5; r++) begin
         drive_rsp(5'(r), 32'h1111_0000 | 32'(r), 5'(r));
         tick();
      end
      apu_rvalid_i = 1'b0; apu_gnt_i = 1'b0;
      tick();
      neg(); check("t3_idle", busy_o, 1'b0);
      tick();

      // 4: destination hazard on rd=7
      drive_cmd(5'd7, 6'h01);
      neg(); check("t4_first", cmd_ready_o, 1'b1);
      req_q.push_back(req_exp(5'd7, 6'h01));
      tick();
      drive_cmd(5'd7, 6'h03);
      apu_gnt_i = 1'b1;
      neg(); check("t4_hazard_gnt", cmd_ready_o, 1'b0);
      tick();
      apu_gnt_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         neg(); check("t4_hazard", cmd_ready_o, 1'b0);
         tick();
      end
      drive_rsp(5'd7, 32'h7777_0001, 5'h04);
      neg(); check("t4_release", cmd_ready_o, 1'b1);
      req_q.push_back(req_exp(5'd7, 6'h03));
      tick();
      cmd_valid_i = 1'b0; apu_rvalid_i = 1'b0; apu_gnt_i = 1'b1;
      tick();
      apu_gnt_i = 1'b0;
      drive_rsp(5'd7, 32'h7777_0002, 5'h08);
      tick();
      apu_rvalid_i = 1'b0;
      tick();
      neg(); check("t4_idle", busy_o, 1'b0);
      tick();

      // 5: spurious response
      neg(); check("t5_err_before", err_o, 1'b0);
      tick();
      apu_rvalid_i = 1'b1; apu_rdata_i = 32'hDEAD_BEEF;
      tick();
      apu_rvalid_i = 1'b0;
      neg(); check("t5_err_set", {err_o, wb_valid_o, busy_o}, 3'b100);
      tick(); tick(); tick();
      neg(); check("t5_err_sticky", err_o, 1'b1);
      tick();

      // 6: reset with three ops in flight
      apu_gnt_i = 1'b1;
      for (int r = 11; r <= 13; r++) begin
         drive_cmd(5'(r), 6'h04);
         req_q.push_back(req_exp(5'(r), 6'h04));
         tick();
      end
      cmd_valid_i = 1'b0; rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1; apu_gnt_i = 1'b0;
      neg();
      check("t6_ctrl", {apu_req_o, wb_valid_o, busy_o, err_o}, 4'b0000);
      check("t6_payload", {apu_operands_o, apu_op_o, apu_flags_o}, '0);
      check("t6_wb", {wb_rd_o, wb_data_o, wb_flags_o}, '0);
      tick();
      apu_rvalid_i = 1'b1; apu_rdata_i = 32'h1234_5678;
      tick();
      apu_rvalid_i = 1'b0;
      neg(); check("t6_err_no_wb", {err_o, wb_valid_o}, 2'b10);
      tick(); tick();

      check("req_queue_drained", 32'(req_q.size()), 32'd0);
      check("wb_queue_drained", 32'(wb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
